sys_ctrl: RTL and testbench

Command sequencer between the UART RX byte stream and the system resources (register file, ALU) and the UART TX path.
- Decodes multi-byte command frames from RX and issues register-file write/read and ALU operations.
- Returns read data and ALU results as bytes into the TX-side FIFO, which crosses into the TX clock domain.
- Sits in the RX/system clock domain, between UART RX, the register file, the ALU and the async TX FIFO.

---
 rtl/sys_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between the UART RX byte stream, the register
// file, the ALU and the TX-side FIFO. Decodes AA/BB/CC/DD frames, issues
// one-cycle RF/ALU strobes and pushes read data / ALU results into the FIFO.
module sys_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPR = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    output logic [3:0]              ALU_FUN,
    output logic                    ALU_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
    output logic                    FIFO_WR_EN,
    input  logic                    FIFO_FULL,
    output logic                    BUSY
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPR_A, OPR_B,
        ALU_FUN_S, ALU_WAIT, TX_B0, TX_B1
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [2*DATA_WIDTH-1:0] result_q, result_n;
    logic                    two_byte_q, two_byte_n;

    logic [ADDR_WIDTH-1:0]   rf_addr_n;
    logic [DATA_WIDTH-1:0]   rf_wr_data_n;
    logic                    rf_wr_en_n;
    logic                    rf_rd_en_n;
    logic [3:0]              alu_fun_n;
    logic                    alu_en_n;
    logic [DATA_WIDTH-1:0]   fifo_wr_data_n;
    logic                    fifo_wr_en_n;
    logic                    busy_n;

    // State, internal registers and all outputs are registered here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            addr_q       <= '0;
            result_q     <= '0;
            two_byte_q   <= 1'b0;
            RF_ADDR      <= '0;
            RF_WR_DATA   <= '0;
            RF_WR_EN     <= 1'b0;
            RF_RD_EN     <= 1'b0;
            ALU_FUN      <= '0;
            ALU_EN       <= 1'b0;
            FIFO_WR_DATA <= '0;
            FIFO_WR_EN   <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state        <= state_n;
            addr_q       <= addr_n;
            result_q     <= result_n;
            two_byte_q   <= two_byte_n;
            RF_ADDR      <= rf_addr_n;
            RF_WR_DATA   <= rf_wr_data_n;
            RF_WR_EN     <= rf_wr_en_n;
            RF_RD_EN     <= rf_rd_en_n;
            ALU_FUN      <= alu_fun_n;
            ALU_EN       <= alu_en_n;
            FIFO_WR_DATA <= fifo_wr_data_n;
            FIFO_WR_EN   <= fifo_wr_en_n;
            BUSY         <= busy_n;
        end
    end

    // Next-state and next-output logic. FIFO pushes are decided one edge
    // ahead: FIFO_WR_EN is the registered copy of "not full", so a TX_Bx
    // state with FIFO_WR_EN high is the cycle in which that byte is pushed.
    always_comb begin
        state_n        = state;
        addr_n         = addr_q;
        result_n       = result_q;
        two_byte_n     = two_byte_q;
        rf_addr_n      = RF_ADDR;
        rf_wr_data_n   = RF_WR_DATA;
        rf_wr_en_n     = 1'b0;
        rf_rd_en_n     = 1'b0;
        alu_fun_n      = ALU_FUN;
        alu_en_n       = 1'b0;
        fifo_wr_data_n = FIFO_WR_DATA;
        fifo_wr_en_n   = 1'b0;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_n = WR_ADDR;
                        CMD_RF_RD:   state_n = RD_ADDR;
                        CMD_ALU_OPR: state_n = OPR_A;
                        CMD_ALU_NOP: state_n = ALU_FUN_S;
                        default:     state_n = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = addr_q;
                    rf_wr_data_n = RX_P_DATA;
                    state_n      = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_n = 1'b1;
                    rf_addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_n    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RD_DATA_VLD) begin
                    result_n       = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    two_byte_n     = 1'b0;
                    fifo_wr_data_n = RF_RD_DATA;
                    fifo_wr_en_n   = !FIFO_FULL;
                    state_n        = TX_B0;
                end
            end
            OPR_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = '0;
                    rf_wr_data_n = RX_P_DATA;
                    state_n      = OPR_B;
                end
            end
            OPR_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = ADDR_WIDTH'(1);
                    rf_wr_data_n = RX_P_DATA;
                    state_n      = ALU_FUN_S;
                end
            end
            ALU_FUN_S: begin
                if (RX_D_VLD) begin
                    alu_fun_n = RX_P_DATA[3:0];
                    alu_en_n  = 1'b1;
                    state_n   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_n       = ALU_OUT;
                    two_byte_n     = 1'b1;
                    fifo_wr_data_n = ALU_OUT[DATA_WIDTH-1:0];
                    fifo_wr_en_n   = !FIFO_FULL;
                    state_n        = TX_B0;
                end
            end
            TX_B0: begin
                if (FIFO_WR_EN) begin
                    if (two_byte_q) begin
                        fifo_wr_data_n = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        fifo_wr_en_n   = !FIFO_FULL;
                        state_n        = TX_B1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    fifo_wr_data_n = result_q[DATA_WIDTH-1:0];
                    fifo_wr_en_n   = !FIFO_FULL;
                end
            end
            TX_B1: begin
                if (FIFO_WR_EN) begin
                    state_n = IDLE;
                end else begin
                    fifo_wr_data_n = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    fifo_wr_en_n   = !FIFO_FULL;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed plus randomized frames checked against a frame-level
// reference model (expected RF writes/reads, ALU starts and FIFO bytes).
module tb_sys_ctrl;

    localparam logic [7:0] C_WR  = 8'hAA;
    localparam logic [7:0] C_RD  = 8'hBB;
    localparam logic [7:0] C_OPR = 8'hCC;
    localparam logic [7:0] C_NOP = 8'hDD;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_ADDR;
    logic [7:0]  RF_WR_DATA;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_DATA_VLD;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  FIFO_WR_DATA;
    logic        FIFO_WR_EN;
    logic        FIFO_FULL;
    logic        BUSY;

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_EN(FIFO_WR_EN),
        .FIFO_FULL(FIFO_FULL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int full_viol = 0;
    logic full_at_edge = 1'b0;

    logic [7:0]  mem [16];
    logic [11:0] wr_q[$],  ex_wr[$];
    logic [3:0]  rd_q[$],  ex_rd[$];
    logic [3:0]  alu_q[$], ex_alu[$];
    logic [7:0]  fifo_q[$], ex_fifo[$];

    // FIFO_FULL as seen by the DUT at each active edge.
    always @(posedge CLK) full_at_edge <= FIFO_FULL;

    // Observed strobes are collected for comparison against the model.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (RF_WR_EN) wr_q.push_back({RF_ADDR, RF_WR_DATA});
            if (RF_RD_EN) rd_q.push_back(RF_ADDR);
            if (ALU_EN)   alu_q.push_back(ALU_FUN);
            if (FIFO_WR_EN) begin
                fifo_q.push_back(FIFO_WR_DATA);
                if (full_at_edge) full_viol++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_addr"}, RF_ADDR, 0);
        chk({tag, "_rf_wdata"}, RF_WR_DATA, 0);
        chk({tag, "_rf_wr_en"}, RF_WR_EN, 0);
        chk({tag, "_rf_rd_en"}, RF_RD_EN, 0);
        chk({tag, "_alu_fun"}, ALU_FUN, 0);
        chk({tag, "_alu_en"}, ALU_EN, 0);
        chk({tag, "_fifo_data"}, FIFO_WR_DATA, 0);
        chk({tag, "_fifo_en"}, FIFO_WR_EN, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    task automatic compare_all();
        tick();
        tick();
        chk("wr_cnt", wr_q.size(), ex_wr.size());
        while (wr_q.size() > 0 && ex_wr.size() > 0) chk("wr_evt", wr_q.pop_front(), ex_wr.pop_front());
        chk("rd_cnt", rd_q.size(), ex_rd.size());
        while (rd_q.size() > 0 && ex_rd.size() > 0) chk("rd_evt", rd_q.pop_front(), ex_rd.pop_front());
        chk("alu_cnt", alu_q.size(), ex_alu.size());
        while (alu_q.size() > 0 && ex_alu.size() > 0) chk("alu_evt", alu_q.pop_front(), ex_alu.pop_front());
        chk("fifo_cnt", fifo_q.size(), ex_fifo.size());
        while (fifo_q.size() > 0 && ex_fifo.size() > 0) chk("fifo_byte", fifo_q.pop_front(), ex_fifo.pop_front());
        wr_q.delete();  ex_wr.delete();
        rd_q.delete();  ex_rd.delete();
        alu_q.delete(); ex_alu.delete();
        fifo_q.delete(); ex_fifo.delete();
        chk("busy_idle", BUSY, 0);
        chk("full_viol", full_viol, 0);
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(8'($urandom));
            chk("busy_wait", BUSY, 1);
        end
    endtask

    // Return read data / ALU result, optionally with the FIFO full for a while.
    task automatic respond(input bit is_alu, input logic [15:0] val, input int full_cyc);
        FIFO_FULL = (full_cyc > 0);
        if (is_alu) begin
            ALU_OUT = val; ALU_OUT_VLD = 1'b1;
        end else begin
            RF_RD_DATA = val[7:0]; RF_RD_DATA_VLD = 1'b1;
        end
        tick();
        ALU_OUT_VLD = 1'b0;
        RF_RD_DATA_VLD = 1'b0;
        ALU_OUT = 16'($urandom);
        RF_RD_DATA = 8'($urandom);
        if (full_cyc == 0) begin
            chk("tx_latency", FIFO_WR_EN, 1);
            chk("tx_first", FIFO_WR_DATA, val[7:0]);
        end else begin
            for (int i = 0; i < full_cyc; i++) begin
                chk("stall_en", FIFO_WR_EN, 0);
                chk("stall_data", FIFO_WR_DATA, val[7:0]);
                if (i == full_cyc - 1) FIFO_FULL = 1'b0;
                tick();
            end
        end
        for (int i = 0; i < 40 && fifo_q.size() < ex_fifo.size(); i++) tick();
    endtask

    task automatic f_wr(input logic [7:0] a, input logic [7:0] d);
        strobe(C_WR);
        strobe(a);
        strobe(d);
        chk("wr_latency", RF_WR_EN, 1);
        chk("wr_addr", RF_ADDR, a[3:0]);
        chk("wr_data", RF_WR_DATA, d);
        ex_wr.push_back({a[3:0], d});
        mem[a[3:0]] = d;
        tick();
        chk("wr_one_cycle", RF_WR_EN, 0);
        compare_all();
    endtask

    task automatic f_rd(input logic [7:0] a, input int full_cyc, input int junk);
        strobe(C_RD);
        strobe(a);
        chk("rd_latency", RF_RD_EN, 1);
        chk("rd_addr", RF_ADDR, a[3:0]);
        ex_rd.push_back(a[3:0]);
        ex_fifo.push_back(mem[a[3:0]]);
        tick();
        chk("rd_one_cycle", RF_RD_EN, 0);
        send_junk(junk);
        respond(1'b0, {8'h00, mem[a[3:0]]}, full_cyc);
        compare_all();
    endtask

    task automatic f_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] fn, input logic [15:0] res,
                         input int full_cyc, input int junk);
        if (ops) begin
            strobe(C_OPR);
            strobe(a);
            chk("opa_wr_en", RF_WR_EN, 1);
            chk("opa_addr", RF_ADDR, 0);
            chk("opa_data", RF_WR_DATA, a);
            strobe(b);
            chk("opb_wr_en", RF_WR_EN, 1);
            chk("opb_addr", RF_ADDR, 1);
            chk("opb_data", RF_WR_DATA, b);
            ex_wr.push_back({4'h0, a});
            ex_wr.push_back({4'h1, b});
            mem[0] = a;
            mem[1] = b;
        end else begin
            strobe(C_NOP);
        end
        strobe(fn);
        chk("alu_latency", ALU_EN, 1);
        chk("alu_fun", ALU_FUN, fn[3:0]);
        ex_alu.push_back(fn[3:0]);
        ex_fifo.push_back(res[7:0]);
        ex_fifo.push_back(res[15:8]);
        send_junk(junk);
        respond(1'b1, res, full_cyc);
        compare_all();
    endtask

    initial begin
        logic [7:0] jb;
        RST = 1'b0;
        RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
        FIFO_FULL = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tick();
        tick();
        chk_all_zero("reset");
        RST = 1'b1;
        tick();

        // Directed frames.
        f_wr(8'h05, 8'h3C);
        f_rd(8'h05, 0, 0);
        f_alu(1'b1, 8'h0A, 8'h03, 8'h02, 16'h001E, 0, 0);
        f_alu(1'b0, 8'h00, 8'h00, 8'h00, 16'h1234, 10, 0);

        // Non-command byte in IDLE, then bytes dropped while waiting on the ALU.
        strobe(8'h55);
        chk("idle_ignore_busy", BUSY, 0);
        compare_all();
        f_alu(1'b0, 8'h00, 8'h00, 8'h01, 16'hBEEF, 0, 3);
        f_wr(8'h03, C_WR);
        f_wr(8'hFE, C_RD);

        // Reset in the middle of a write frame.
        strobe(C_WR);
        strobe(8'h07);
        RST = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        RST = 1'b1;
        tick();
        strobe(8'h3C);
        compare_all();
        f_rd(8'h07, 0, 0);
        f_rd(8'h0E, 2, 1);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: f_wr(8'($urandom), 8'($urandom));
                1: f_rd(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                2: f_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                3: f_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                default: begin
                    do jb = 8'($urandom);
                    while (jb == C_WR || jb == C_RD || jb == C_OPR || jb == C_NOP);
                    strobe(jb);
                    compare_all();
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
